// File: rtl/ysyx_22040237_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22040237_idu_stage
// Brief    : Registered RV32I/RV64I decode stage between IFU and EXU, with a
//            single-entry output register, valid/ready handshakes and flush.
//            Optional macro YSYX_22040237_IDU_ILLEGAL_TRAP_EN adds a sticky
//            illegal_o flag that blocks further input until reset.
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22040237_idu_stage #(
    parameter int XLEN   = 64,
    parameter int INFO_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       inst_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic              flush_i,
    output logic [4:0]        rs1_idx_o,
    output logic [4:0]        rs2_idx_o,
    input  logic [XLEN-1:0]   rs1_data_i,
    input  logic [XLEN-1:0]   rs2_data_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   pc_o,
    output logic              rd_wr_en_o,
    output logic [4:0]        rd_idx_o,
    output logic [XLEN-1:0]   op1_o,
    output logic [XLEN-1:0]   op2_o,
    output logic [XLEN-1:0]   op1_jp_o,
    output logic [XLEN-1:0]   op2_jp_o,
    output logic [INFO_W-1:0] exu_info_o,
    output logic              word_op_o,
    output logic              ls_load_o,
    output logic              ls_store_o,
    output logic [1:0]        ls_size_o,
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
    output logic              illegal_o,
`endif
    output logic              ls_unsigned_o
);

    localparam logic [6:0]  c_OPC_LOAD    = 7'b0000011;
    localparam logic [6:0]  c_OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0]  c_OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0]  c_OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0]  c_OPC_STORE   = 7'b0100011;
    localparam logic [6:0]  c_OPC_OP      = 7'b0110011;
    localparam logic [6:0]  c_OPC_LUI     = 7'b0110111;
    localparam logic [6:0]  c_OPC_OP32    = 7'b0111011;
    localparam logic [6:0]  c_OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0]  c_OPC_JALR    = 7'b1100111;
    localparam logic [6:0]  c_OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  c_OPC_SYSTEM  = 7'b1110011;
    localparam logic [31:0] c_INST_EBREAK = 32'h0010_0073;
    localparam bit          c_RV64        = (XLEN == 64);

    // Unit select codes in exu_info[2:0]; op one-hot bits start at bit 3.
    localparam logic [2:0]  c_UNIT_ALU = 3'd1;
    localparam logic [2:0]  c_UNIT_BJP = 3'd2;
    localparam logic [2:0]  c_UNIT_LS  = 3'd3;
    localparam logic [2:0]  c_UNIT_SYS = 3'd4;

    localparam int c_ALU_ADD  = 3;
    localparam int c_ALU_SUB  = 4;
    localparam int c_ALU_SLL  = 5;
    localparam int c_ALU_SLT  = 6;
    localparam int c_ALU_SLTU = 7;
    localparam int c_ALU_XOR  = 8;
    localparam int c_ALU_SRL  = 9;
    localparam int c_ALU_SRA  = 10;
    localparam int c_ALU_OR   = 11;
    localparam int c_ALU_AND  = 12;
    localparam int c_ALU_LUI  = 13;

    localparam int c_BJP_JAL  = 3;
    localparam int c_BJP_JALR = 4;
    localparam int c_BJP_BEQ  = 5;
    localparam int c_BJP_BNE  = 6;
    localparam int c_BJP_BLT  = 7;
    localparam int c_BJP_BGE  = 8;
    localparam int c_BJP_BLTU = 9;
    localparam int c_BJP_BGEU = 10;

    localparam int c_LS_LOAD    = 3;
    localparam int c_LS_STORE   = 4;
    localparam int c_SYS_EBREAK = 3;

    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // alt selects SUB/SRA; callers pass 0 where bit 30 is an immediate bit.
    function automatic logic [14:0] alu_info(input logic [2:0] f3, input logic alt);
        logic [14:0] v;
        v      = '0;
        v[2:0] = c_UNIT_ALU;
        case (f3)
            3'b000:  v[alt ? c_ALU_SUB : c_ALU_ADD] = 1'b1;
            3'b001:  v[c_ALU_SLL]                   = 1'b1;
            3'b010:  v[c_ALU_SLT]                   = 1'b1;
            3'b011:  v[c_ALU_SLTU]                  = 1'b1;
            3'b100:  v[c_ALU_XOR]                   = 1'b1;
            3'b101:  v[alt ? c_ALU_SRA : c_ALU_SRL] = 1'b1;
            3'b110:  v[c_ALU_OR]                    = 1'b1;
            default: v[c_ALU_AND]                   = 1'b1;
        endcase
        return v;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic            w_sh_logic, w_sh_arith;
    logic            w_valid, w_wr_rd, w_word, w_load, w_store, w_uns;
    logic [1:0]      w_size;
    logic [14:0]     w_info15;
    logic [XLEN-1:0] w_op1, w_op2, w_op1_jp, w_op2_jp;
    logic            w_fire;

    assign w_opcode  = inst_i[6:0];
    assign w_funct3  = inst_i[14:12];
    assign w_funct7  = inst_i[31:25];
    assign w_rd      = inst_i[11:7];
    assign rs1_idx_o = inst_i[19:15];
    assign rs2_idx_o = inst_i[24:20];

    assign w_imm_i = sext32({{20{inst_i[31]}}, inst_i[31:20]});
    assign w_imm_s = sext32({{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]});
    assign w_imm_b = sext32({{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0});
    assign w_imm_u = sext32({inst_i[31:12], 12'b0});
    assign w_imm_j = sext32({{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0});

    // Legal upper immediate bits for shift-immediates depend on shamt width.
    generate
        if (XLEN == 64) begin : g_shamt64
            assign w_sh_logic = (inst_i[31:26] == 6'b000000);
            assign w_sh_arith = (inst_i[31:26] == 6'b010000);
        end else begin : g_shamt32
            assign w_sh_logic = (inst_i[31:25] == 7'b0000000);
            assign w_sh_arith = (inst_i[31:25] == 7'b0100000);
        end
    endgenerate

    always_comb begin
        w_valid  = 1'b0;
        w_wr_rd  = 1'b0;
        w_word   = 1'b0;
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_uns    = 1'b0;
        w_size   = 2'd0;
        w_info15 = '0;
        w_op1    = rs1_data_i;
        w_op2    = rs2_data_i;
        w_op1_jp = '0;
        w_op2_jp = '0;
        case (w_opcode)
            c_OPC_OP: begin
                w_wr_rd  = 1'b1;
                w_info15 = alu_info(w_funct3, inst_i[30]);
                w_valid  = (w_funct7 == 7'b0000000) ||
                           ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
            end
            c_OPC_OP32: begin
                w_wr_rd  = 1'b1;
                w_word   = 1'b1;
                w_info15 = alu_info(w_funct3, inst_i[30]);
                w_valid  = c_RV64 &&
                           (((w_funct7 == 7'b0000000) && (w_funct3 inside {3'b000, 3'b001, 3'b101})) ||
                            ((w_funct7 == 7'b0100000) && (w_funct3 inside {3'b000, 3'b101})));
            end
            c_OPC_OPIMM: begin
                w_wr_rd  = 1'b1;
                w_op2    = w_imm_i;
                w_info15 = alu_info(w_funct3, (w_funct3 == 3'b101) && inst_i[30]);
                case (w_funct3)
                    3'b001:  w_valid = w_sh_logic;
                    3'b101:  w_valid = w_sh_logic || w_sh_arith;
                    default: w_valid = 1'b1;
                endcase
            end
            c_OPC_OPIMM32: begin
                w_wr_rd  = 1'b1;
                w_word   = 1'b1;
                w_op2    = w_imm_i;
                w_info15 = alu_info(w_funct3, (w_funct3 == 3'b101) && inst_i[30]);
                w_valid  = c_RV64 &&
                           ((w_funct3 == 3'b000) ||
                            ((w_funct3 == 3'b001) && (w_funct7 == 7'b0000000)) ||
                            ((w_funct3 == 3'b101) && ((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000))));
            end
            c_OPC_LOAD: begin
                w_wr_rd             = 1'b1;
                w_load              = 1'b1;
                w_op2               = w_imm_i;
                w_size              = w_funct3[1:0];
                w_uns               = w_funct3[2];
                w_info15[2:0]       = c_UNIT_LS;
                w_info15[c_LS_LOAD] = 1'b1;
                w_valid             = (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                                      (c_RV64 && (w_funct3 inside {3'b011, 3'b110}));
            end
            c_OPC_STORE: begin
                w_store              = 1'b1;
                w_op2                = w_imm_s;
                w_size               = w_funct3[1:0];
                w_info15[2:0]        = c_UNIT_LS;
                w_info15[c_LS_STORE] = 1'b1;
                w_valid              = !w_funct3[2] && ((w_funct3[1:0] != 2'b11) || c_RV64);
            end
            c_OPC_BRANCH: begin
                w_op1_jp      = pc_i;
                w_op2_jp      = w_imm_b;
                w_info15[2:0] = c_UNIT_BJP;
                w_valid       = (w_funct3[2:1] != 2'b01);
                case (w_funct3)
                    3'b000:  w_info15[c_BJP_BEQ]  = 1'b1;
                    3'b001:  w_info15[c_BJP_BNE]  = 1'b1;
                    3'b100:  w_info15[c_BJP_BLT]  = 1'b1;
                    3'b101:  w_info15[c_BJP_BGE]  = 1'b1;
                    3'b110:  w_info15[c_BJP_BLTU] = 1'b1;
                    default: w_info15[c_BJP_BGEU] = 1'b1;
                endcase
            end
            c_OPC_JAL: begin
                w_valid             = 1'b1;
                w_wr_rd             = 1'b1;
                w_op1               = pc_i;
                w_op2               = c_FOUR;
                w_op1_jp            = pc_i;
                w_op2_jp            = w_imm_j;
                w_info15[2:0]       = c_UNIT_BJP;
                w_info15[c_BJP_JAL] = 1'b1;
            end
            c_OPC_JALR: begin
                w_valid              = (w_funct3 == 3'b000);
                w_wr_rd              = 1'b1;
                w_op1                = pc_i;
                w_op2                = c_FOUR;
                w_op1_jp             = rs1_data_i;
                w_op2_jp             = w_imm_i;
                w_info15[2:0]        = c_UNIT_BJP;
                w_info15[c_BJP_JALR] = 1'b1;
            end
            c_OPC_LUI: begin
                w_valid             = 1'b1;
                w_wr_rd             = 1'b1;
                w_op2               = w_imm_u;
                w_info15[2:0]       = c_UNIT_ALU;
                w_info15[c_ALU_LUI] = 1'b1;
            end
            c_OPC_AUIPC: begin
                w_valid             = 1'b1;
                w_wr_rd             = 1'b1;
                w_op1               = pc_i;
                w_op2               = w_imm_u;
                w_info15[2:0]       = c_UNIT_ALU;
                w_info15[c_ALU_ADD] = 1'b1;
            end
            c_OPC_SYSTEM: begin
                w_valid                = (inst_i == c_INST_EBREAK);
                w_info15[2:0]          = c_UNIT_SYS;
                w_info15[c_SYS_EBREAK] = 1'b1;
            end
            default: w_valid = 1'b0;
        endcase
        // Anything not recognised leaves as a bubble with no side effects.
        if (!w_valid) begin
            w_wr_rd  = 1'b0;
            w_word   = 1'b0;
            w_load   = 1'b0;
            w_store  = 1'b0;
            w_uns    = 1'b0;
            w_size   = 2'd0;
            w_info15 = '0;
        end
    end

    logic              r_out_valid;
    logic [XLEN-1:0]   r_pc, r_op1, r_op2, r_op1_jp, r_op2_jp;
    logic              r_rd_wr_en, r_word, r_load, r_store, r_uns;
    logic [4:0]        r_rd_idx;
    logic [1:0]        r_size;
    logic [INFO_W-1:0] r_info;

`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
    logic r_illegal;
    assign in_ready  = !r_illegal && (!r_out_valid || out_ready);
    assign illegal_o = r_illegal;
`else
    assign in_ready  = !r_out_valid || out_ready;
`endif

    assign w_fire = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_op1_jp    <= '0;
            r_op2_jp    <= '0;
            r_rd_wr_en  <= 1'b0;
            r_rd_idx    <= 5'd0;
            r_info      <= '0;
            r_word      <= 1'b0;
            r_load      <= 1'b0;
            r_store     <= 1'b0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
            r_illegal   <= 1'b0;
`endif
        end else begin
            if (flush_i) begin
                r_out_valid <= 1'b0;
            end else if (w_fire) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_fire && !flush_i) begin
                r_pc       <= pc_i;
                r_op1      <= w_op1;
                r_op2      <= w_op2;
                r_op1_jp   <= w_op1_jp;
                r_op2_jp   <= w_op2_jp;
                r_rd_wr_en <= w_wr_rd && (w_rd != 5'd0);
                r_rd_idx   <= w_rd;
                r_info     <= INFO_W'(w_info15);
                r_word     <= w_word;
                r_load     <= w_load;
                r_store    <= w_store;
                r_size     <= w_size;
                r_uns      <= w_uns;
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
                if (!w_valid) begin
                    r_illegal <= 1'b1;
                end
`endif
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign pc_o          = r_pc;
    assign op1_o         = r_op1;
    assign op2_o         = r_op2;
    assign op1_jp_o      = r_op1_jp;
    assign op2_jp_o      = r_op2_jp;
    assign rd_wr_en_o    = r_rd_wr_en;
    assign rd_idx_o      = r_rd_idx;
    assign exu_info_o    = r_info;
    assign word_op_o     = r_word;
    assign ls_load_o     = r_load;
    assign ls_store_o    = r_store;
    assign ls_size_o     = r_size;
    assign ls_unsigned_o = r_uns;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22040237_idu_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22040237_idu_stage
// Brief    : Scoreboard bench for the decode stage (64-bit main DUT plus a
//            32-bit instance for width-dependent legality).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22040237_idu_stage;

    typedef struct {
        logic [63:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [63:0] op1, op2, j1, j2;
        logic [14:0] info;
        logic        word, ld, st;
        logic [1:0]  sz;
        logic        uns;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, flush_i = 1'b0, out_ready = 1'b1;
    logic [31:0] inst_i = 32'h0;
    logic [63:0] pc_i = '0, rs1_data_i = '0, rs2_data_i = '0;
    logic        in_ready, out_valid, rd_wr_en_o, word_op_o, ls_load_o, ls_store_o, ls_unsigned_o;
    logic [4:0]  rs1_idx_o, rs2_idx_o, rd_idx_o;
    logic [63:0] pc_o, op1_o, op2_o, op1_jp_o, op2_jp_o;
    logic [14:0] exu_info_o;
    logic [1:0]  ls_size_o;
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
    logic        illegal_o, d_illegal;
`endif

    logic        d_in_valid = 1'b0, d_in_ready, d_out_valid;
    logic [31:0] d_inst = 32'h0, d_pc = 32'h0, d_rs1 = 32'h0, d_rs2 = 32'h0;
    logic [4:0]  d_rs1_idx, d_rs2_idx, d_rd_idx;
    logic [31:0] d_pc_o, d_op1, d_op2, d_j1, d_j2;
    logic        d_we, d_word, d_ld, d_st, d_uns;
    logic [14:0] d_info;
    logic [1:0]  d_sz;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ysyx_22040237_idu_stage #(.XLEN(64), .INFO_W(15)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst_i(inst_i),
        .pc_i(pc_i), .flush_i(flush_i), .rs1_idx_o(rs1_idx_o), .rs2_idx_o(rs2_idx_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .out_valid(out_valid),
        .out_ready(out_ready), .pc_o(pc_o), .rd_wr_en_o(rd_wr_en_o), .rd_idx_o(rd_idx_o),
        .op1_o(op1_o), .op2_o(op2_o), .op1_jp_o(op1_jp_o), .op2_jp_o(op2_jp_o),
        .exu_info_o(exu_info_o), .word_op_o(word_op_o), .ls_load_o(ls_load_o),
        .ls_store_o(ls_store_o), .ls_size_o(ls_size_o),
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
        .illegal_o(illegal_o),
`endif
        .ls_unsigned_o(ls_unsigned_o)
    );

    ysyx_22040237_idu_stage #(.XLEN(32), .INFO_W(15)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .inst_i(d_inst),
        .pc_i(d_pc), .flush_i(1'b0), .rs1_idx_o(d_rs1_idx), .rs2_idx_o(d_rs2_idx),
        .rs1_data_i(d_rs1), .rs2_data_i(d_rs2), .out_valid(d_out_valid),
        .out_ready(1'b1), .pc_o(d_pc_o), .rd_wr_en_o(d_we), .rd_idx_o(d_rd_idx),
        .op1_o(d_op1), .op2_o(d_op2), .op1_jp_o(d_j1), .op2_jp_o(d_j2),
        .exu_info_o(d_info), .word_op_o(d_word), .ls_load_o(d_ld),
        .ls_store_o(d_st), .ls_size_o(d_sz),
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
        .illegal_o(d_illegal),
`endif
        .ls_unsigned_o(d_uns)
    );

    function automatic exp_t mk(input logic [63:0] pc, input logic we, input logic [4:0] rd,
                                input logic [63:0] a, input logic [63:0] b,
                                input logic [63:0] j1, input logic [63:0] j2,
                                input logic [14:0] info, input logic w, input logic ld,
                                input logic st, input logic [1:0] sz, input logic u);
        exp_t e;
        e.pc = pc; e.we = we; e.rd = rd; e.op1 = a; e.op2 = b; e.j1 = j1; e.j2 = j2;
        e.info = info; e.word = w; e.ld = ld; e.st = st; e.sz = sz; e.uns = u; e.chk = 1'b1;
        return e;
    endfunction

    function automatic exp_t bub(input logic [63:0] pc);
        exp_t e;
        e = mk(pc, 1'b0, 5'd0, '0, '0, '0, '0, 15'h0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        e.chk = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: every output accepted by the EXU is compared with the oldest expectation.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got output pc=%h with no expectation", pc_o);
                end else begin
                    e  = sb.pop_front();
                    ok = (pc_o === e.pc) && (rd_wr_en_o === e.we) && (exu_info_o === e.info) &&
                         (word_op_o === e.word) && (ls_load_o === e.ld) && (ls_store_o === e.st);
                    if (e.chk)
                        ok = ok && (rd_idx_o === e.rd) && (op1_o === e.op1) && (op2_o === e.op2) &&
                             (op1_jp_o === e.j1) && (op2_jp_o === e.j2) &&
                             (ls_size_o === e.sz) && (ls_unsigned_o === e.uns);
                    if (!ok) begin
                        failures++;
                        $display("FAIL decode pc=%h: got we=%b rd=%0d op1=%h op2=%h j1=%h j2=%h info=%h w=%b ld=%b st=%b sz=%0d u=%b; want we=%b rd=%0d op1=%h op2=%h j1=%h j2=%h info=%h w=%b ld=%b st=%b sz=%0d u=%b",
                                 e.pc, rd_wr_en_o, rd_idx_o, op1_o, op2_o, op1_jp_o, op2_jp_o,
                                 exu_info_o, word_op_o, ls_load_o, ls_store_o, ls_size_o, ls_unsigned_o,
                                 e.we, e.rd, e.op1, e.op2, e.j1, e.j2, e.info, e.word, e.ld, e.st,
                                 e.sz, e.uns);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] inst, input logic [63:0] pc,
                         input logic [63:0] r1, input logic [63:0] r2, input exp_t e);
        int n;
        n = 0;
        in_valid = 1'b1; inst_i = inst; pc_i = pc; rs1_data_i = r1; rs2_data_i = r2;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%b want 1 for inst %h", in_ready, inst);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic run32(input logic [31:0] inst, input logic [31:0] r1, input logic [31:0] r2);
        d_in_valid = 1'b1; d_inst = inst; d_pc = 32'h8000_0000; d_rs1 = r1; d_rs2 = r2;
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        exp_t ea;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_pc", pc_o, 64'd0);
        chk("rst_info", 64'(exu_info_o), 64'd0);
        chk("rst_we", 64'(rd_wr_en_o), 64'd0);
        @(posedge clk); #1;

        // RV32 instance: width-dependent legality.
        run32(32'h0050_0093, 32'h0, 32'h0);
        chk("rv32_addi_valid", 64'(d_out_valid), 64'd1);
        chk("rv32_addi_op2", 64'(d_op2), 64'd5);
        chk("rv32_addi_info", 64'(d_info), 64'h009);
        run32(32'h0071_3823, 32'h2000, 32'h0);
        chk("rv32_sd_store", 64'(d_st), 64'd0);
        chk("rv32_sd_info", 64'(d_info), 64'd0);
        pulse_rst();
        run32(32'h0020_81BB, 32'h7, 32'h1);
        chk("rv32_addw_valid", 64'(d_out_valid), 64'd1);
        chk("rv32_addw_we", 64'(d_we), 64'd0);
        chk("rv32_addw_info", 64'(d_info), 64'd0);
        pulse_rst();

        // Back-to-back main stream.
        issue(32'h0050_0093, 64'h8000_0000, 64'h0, 64'h0,
              mk(64'h8000_0000, 1, 5'd1, 64'd0, 64'd5, 64'd0, 64'd0, 15'h009, 0, 0, 0, 2'd0, 0));
        issue(32'h0080_00EF, 64'h8000_0004, 64'h0, 64'h0,
              mk(64'h8000_0004, 1, 5'd1, 64'h8000_0004, 64'd4, 64'h8000_0004, 64'd8, 15'h00A, 0, 0, 0, 2'd0, 0));
        issue(32'h0020_81BB, 64'h8000_0008, 64'h7FFF_FFFF, 64'h1,
              mk(64'h8000_0008, 1, 5'd3, 64'h7FFF_FFFF, 64'h1, 64'd0, 64'd0, 15'h009, 1, 0, 0, 2'd0, 0));
        inst_i = 32'h0033_4283;
        #1;
        chk("rs1_idx", 64'(rs1_idx_o), 64'd6);
        chk("rs2_idx", 64'(rs2_idx_o), 64'd3);
        issue(32'h0033_4283, 64'h8000_000C, 64'h1000, 64'h0,
              mk(64'h8000_000C, 1, 5'd5, 64'h1000, 64'd3, 64'd0, 64'd0, 15'h00B, 0, 1, 0, 2'd0, 1));
        issue(32'h0071_3823, 64'h8000_0010, 64'h2000, 64'h55,
              mk(64'h8000_0010, 0, 5'd16, 64'h2000, 64'd16, 64'd0, 64'd0, 15'h013, 0, 0, 1, 2'd3, 0));
        issue(32'hFE20_8EE3, 64'h8000_0100, 64'd5, 64'd6,
              mk(64'h8000_0100, 0, 5'd29, 64'd5, 64'd6, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFC, 15'h022, 0, 0, 0, 2'd0, 0));
        issue(32'h8000_0537, 64'h8000_0104, 64'h0, 64'h0,
              mk(64'h8000_0104, 1, 5'd10, 64'd0, 64'hFFFF_FFFF_8000_0000, 64'd0, 64'd0, 15'h2001, 0, 0, 0, 2'd0, 0));
        issue(32'h0000_1117, 64'h8000_0200, 64'h0, 64'h0,
              mk(64'h8000_0200, 1, 5'd2, 64'h8000_0200, 64'h1000, 64'd0, 64'd0, 15'h009, 0, 0, 0, 2'd0, 0));
        issue(32'h0000_8067, 64'h8000_0300, 64'h8000_1000, 64'h0,
              mk(64'h8000_0300, 0, 5'd0, 64'h8000_0300, 64'd4, 64'h8000_1000, 64'd0, 15'h012, 0, 0, 0, 2'd0, 0));
        issue(32'h4212_5213, 64'h8000_0304, 64'h8000_0000_0000_0000, 64'h0,
              mk(64'h8000_0304, 1, 5'd4, 64'h8000_0000_0000_0000, 64'h421, 64'd0, 64'd0, 15'h401, 0, 0, 0, 2'd0, 0));
        issue(32'h4212_1213, 64'h8000_0308, 64'h0, 64'h0, bub(64'h8000_0308));
        idle(2);

        // Stall: A (sub) held while B (ebreak) waits.
        out_ready = 1'b0;
        ea = mk(64'h8000_0310, 1, 5'd5, 64'd100, 64'd30, 64'd0, 64'd0, 15'h011, 0, 0, 0, 2'd0, 0);
        issue(32'h4073_02B3, 64'h8000_0310, 64'd100, 64'd30, ea);
        in_valid = 1'b1; inst_i = 32'h0010_0073; pc_i = 64'h8000_0314; rs1_data_i = '0; rs2_data_i = '0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            chk("stall_pc", pc_o, ea.pc);
            chk("stall_op1", op1_o, ea.op1);
            chk("stall_op2", op2_o, ea.op2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue(32'h0010_0073, 64'h8000_0314, 64'h0, 64'h0,
              mk(64'h8000_0314, 0, 5'd0, 64'd0, 64'd0, 64'd0, 64'd0, 15'h00C, 0, 0, 0, 2'd0, 0));
        idle(2);

        // Flush coincident with a fire.
        in_valid = 1'b1; flush_i = 1'b1; inst_i = 32'h0050_0093; pc_i = 64'h8000_0400;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        // Reset during a stall discards the held instruction.
        out_ready = 1'b0;
        issue(32'h8000_0537, 64'h8000_0500, 64'h0, 64'h0, bub(64'h8000_0500));
        pulse_rst();
        void'(sb.pop_back());
        @(negedge clk);
        chk("rst_stall_valid", 64'(out_valid), 64'd0);
        chk("rst_stall_pc", pc_o, 64'd0);
        chk("rst_stall_op2", op2_o, 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        // All-ones word is not a legal instruction.
        issue(32'hFFFF_FFFF, 64'h8000_0600, 64'h0, 64'h0, bub(64'h8000_0600));
`ifdef YSYX_22040237_IDU_ILLEGAL_TRAP_EN
        @(negedge clk);
        chk("illegal_set", 64'(illegal_o), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b1; inst_i = 32'h0050_0093;
        repeat (3) begin
            @(negedge clk);
            chk("illegal_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        pulse_rst();
        @(negedge clk);
        chk("illegal_cleared", 64'(illegal_o), 64'd0);
        chk("illegal_rst_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
`else
        issue(32'h0050_0093, 64'h8000_0604, 64'h0, 64'h0,
              mk(64'h8000_0604, 1, 5'd1, 64'd0, 64'd5, 64'd0, 64'd0, 15'h009, 0, 0, 0, 2'd0, 0));
`endif
        idle(3);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
